// File: rtl/alu_shift_iter.sv
// Iterative shift/rotate unit: one bit position per clock, valid/ready request and response ports.
// Shares the processor-wide datapath width through simple_processor_pkg.

package simple_processor_pkg;
    localparam int unsigned DATA_WIDTH = 32;
endpackage

module alu_shift_iter #(
    parameter int unsigned DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
    parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [SHAMT_W-1:0]    shamt_i,
    input  logic [1:0]            op_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  busy_o
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [SHAMT_W-1:0]    cnt_q;
    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  resp_valid_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] step_data;

    // Single-bit step of the operand held in data_q.
    always_comb begin
        step_data = data_q;
        case (op_q)
            OP_SLL:  step_data = {data_q[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  step_data = {1'b0, data_q[DATA_WIDTH-1:1]};
            OP_SRA:  step_data = {data_q[DATA_WIDTH-1], data_q[DATA_WIDTH-1:1]};
            OP_ROR:  step_data = {data_q[0], data_q[DATA_WIDTH-1:1]};
            default: step_data = data_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            data_q       <= '0;
            cnt_q        <= '0;
            op_q         <= '0;
            result_q     <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        data_q <= rs1_data_i;
                        op_q   <= op_i;
                        cnt_q  <= shamt_i;
                        busy_q <= 1'b1;
                        // A zero shift skips straight to the response.
                        if (shamt_i == '0) begin
                            state_q      <= DONE;
                            result_q     <= rs1_data_i;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_q <= step_data;
                    cnt_q  <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q      <= DONE;
                        result_q     <= step_data;
                        resp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready_i) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    // Ready is gated by reset so nothing is accepted while the unit is being cleared.
    assign req_ready_o  = (state_q == IDLE) && !rst_i;
    assign resp_valid_o = resp_valid_q;
    assign result_o     = result_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_alu_shift_iter.sv
// Directed and randomized checks for alu_shift_iter: results, latency, backpressure and reset abort.

module tb_alu_shift_iter;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] rs1_data;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic        busy;

    int passed = 0;
    int total  = 0;

    alu_shift_iter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .rs1_data_i   (rs1_data),
        .shamt_i      (shamt),
        .op_i         (op),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .result_o     (result),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and return in the cycle after acceptance (c+1).
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        int guard;
        guard = 0;
        req_valid = 1'b1;
        op        = o;
        rs1_data  = a;
        shamt     = s;
        while (!req_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        rs1_data  = $urandom;
        shamt     = 5'($urandom);
        op        = 2'($urandom);
    endtask

    // Cycles from acceptance to resp_valid; 1 means resp_valid in c+1.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        logic [31:0] r;
        case (o)
            2'b00:   r = a << s;
            2'b01:   r = a >> s;
            2'b10:   r = $signed(a) >>> s;
            default: r = (a >> s) | (a << (32 - int'(s)));
        endcase
        return r;
    endfunction

    initial begin
        int          lat;
        int          guard;
        logic        seen;
        logic        hs;
        logic        unstable;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [4:0]  rs;
        logic [31:0] exp;

        rst        = 1'b1;
        req_valid  = 1'b0;
        rs1_data   = '0;
        shamt      = '0;
        op         = '0;
        resp_ready = 1'b1;

        // Reset state.
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_result", result, 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        // SLL 1 by 4.
        issue(2'b00, 32'h0000_0001, 5'd4);
        check("sll_busy", 32'(busy), 32'd1);
        check("sll_req_ready_low", 32'(req_ready), 32'd0);
        wait_resp(lat);
        check("sll_latency", 32'(lat), 32'd5);
        check("sll_result", result, 32'h0000_0010);
        tick();
        check("sll_valid_one_cycle", 32'(resp_valid), 32'd0);
        check("sll_idle_ready", 32'(req_ready), 32'd1);

        // SRA / SRL of the sign bit by 31.
        issue(2'b10, 32'h8000_0000, 5'd31);
        wait_resp(lat);
        check("sra31_latency", 32'(lat), 32'd32);
        check("sra31_result", result, 32'hFFFF_FFFF);
        tick();
        issue(2'b01, 32'h8000_0000, 5'd31);
        wait_resp(lat);
        check("srl31_latency", 32'(lat), 32'd32);
        check("srl31_result", result, 32'h0000_0001);
        tick();

        // Rotate wraps bit 0 to the top.
        issue(2'b11, 32'h0000_0001, 5'd1);
        wait_resp(lat);
        check("ror1_latency", 32'(lat), 32'd2);
        check("ror1_result", result, 32'h8000_0000);
        tick();

        // Zero shift for every op passes the operand through in c+1.
        for (int i = 0; i < 4; i++) begin
            issue(2'(i), 32'hDEAD_BEEF, 5'd0);
            wait_resp(lat);
            check($sformatf("sh0_op%0d_latency", i), 32'(lat), 32'd1);
            check($sformatf("sh0_op%0d_result", i), result, 32'hDEAD_BEEF);
            tick();
        end

        // Backpressure holds the response; input changes have no effect.
        resp_ready = 1'b0;
        issue(2'b01, 32'h0000_00F0, 5'd4);
        wait_resp(lat);
        check("bp_latency", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            rs1_data  = $urandom;
            op        = 2'($urandom);
            req_valid = 1'b1;
            check("bp_valid_held", 32'(resp_valid), 32'd1);
            check("bp_result_held", result, 32'h0000_000F);
            check("bp_req_ready_low", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        check("bp_release_busy", 32'(busy), 32'd0);
        check("bp_result_kept", result, 32'h0000_000F);

        // Reset in the middle of a long shift aborts it.
        issue(2'b00, 32'h0000_0003, 5'd20);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_result", result, 32'h0);
        check("abort_req_ready_in_rst", 32'(req_ready), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (resp_valid || busy) seen = 1'b1;
            tick();
        end
        check("abort_no_response", 32'(seen), 32'd0);

        // Randomized regression with random response backpressure.
        unstable = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            ro  = 2'($urandom);
            ra  = $urandom;
            rs  = 5'($urandom);
            exp = model(ro, ra, rs);
            resp_ready = 1'($urandom);
            issue(ro, ra, rs);
            wait_resp(lat);
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(rs) + 32'd1);
            check($sformatf("rnd%0d_result", n), result, exp);
            guard = 0;
            hs    = 1'b0;
            while (!hs && guard < 50) begin
                resp_ready = ($urandom_range(0, 3) != 0);
                hs = resp_ready;
                if (!resp_valid || result !== exp || req_ready) unstable = 1'b1;
                tick();
                guard++;
            end
            if (resp_valid) unstable = 1'b1;
        end
        check("rnd_hold_stable", 32'(unstable), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_shift_iter.md
# alu_shift_iter

Iterative, handshaked shift/rotate unit for the simple processor's ALU: accepts one operand and shift amount through a valid/ready request port, shifts one bit position per clock, and returns the result through a valid/ready response port. It is the multi-cycle, area-reduced counterpart of the combinational ALU shift path. The execute stage issues the request and consumes the response, and stalls on `req_ready_o`/`resp_valid_o`.

## Interface
- `DATA_WIDTH`, default `simple_processor_pkg::DATA_WIDTH` (32): operand/result width; power of two, ≥ 4.
- `SHAMT_W`, default `$clog2(DATA_WIDTH)` (5): shift-amount width; do not override.

Ports:
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  unit can accept a request.
- `rs1_data_i`  in  DATA_WIDTH  operand to shift.
- `shamt_i`  in  SHAMT_W  shift amount, 0..DATA_WIDTH-1.
- `op_i`  in  2  operation: 2'b00 SLL, 2'b01 SRL (logical), 2'b10 SRA (arithmetic), 2'b11 ROR (rotate right).
- `resp_valid_o`  out  1  result available.
- `resp_ready_i`  in  1  consumer takes result.
- `result_o`  out  DATA_WIDTH  shift result; valid while `resp_valid_o`=1.
- `busy_o`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, SHIFT, DONE. Registers: `data_q` (DATA_WIDTH), `cnt_q` (SHAMT_W), `op_q` (2).
- IDLE: `req_ready_o`=1 (forced 0 while `rst_i`=1). On `req_valid_i & req_ready_o`: `data_q`←`rs1_data_i`, `op_q`←`op_i`, `cnt_q`←`shamt_i`; if `shamt_i`=0 go DONE, else go SHIFT.
- SHIFT: each cycle, shift `data_q` by one bit per `op_q`; `cnt_q`←`cnt_q`-1; when `cnt_q`=1 (the last step), go DONE.
- One-bit step per op:
  - SLL: `{data_q[W-2:0],1'b0}`.
  - SRL: `{1'b0,data_q[W-1:1]}`.
  - SRA: `{data_q[W-1],data_q[W-1:1]}`.
  - ROR: `{data_q[0],data_q[W-1:1]}`.
- DONE: `resp_valid_o`=1 and `result_o`=`data_q`, both held stable until `resp_ready_i`=1. On handshake go IDLE. `result_o` keeps its last value after leaving DONE, but is meaningful only when valid.
- Inputs are sampled only at acceptance. Changes on `rs1_data_i`/`op_i`/`shamt_i` during SHIFT/DONE have no effect.
- Every `op_i` encoding is legal; no error path exists.
- Reset values (after any clock edge with `rst_i`=1):
  - state IDLE; `data_q`, `cnt_q`, `op_q` = 0.
  - `resp_valid_o`=0, `result_o`=0, `busy_o`=0.
  - `req_ready_o`=0 while `rst_i` is high, 1 in the first cycle after deassertion.
- Reset mid-operation (SHIFT or DONE) aborts the operation. The pending result is discarded and no response is issued.

## Timing
- Request accepted at the end of cycle c (both valid and ready high in c). `resp_valid_o` rises in cycle c+1+shamt.
  - shamt=0 → cycle c+1.
  - shamt=31 → cycle c+32.
- `req_ready_o` is low from cycle c+1 until the cycle after the response handshake. There is no same-cycle response-accept/request-accept overlap.
- Minimum issue interval is shamt+2 cycles, with `resp_ready_i` tied high.
- `resp_valid_o` is not withdrawn before the handshake. Backpressure of any length holds `result_o` constant.
- All outputs are decoded from registered state or gated by `rst_i`. There is no combinational path from `req_valid_i` or `resp_ready_i` to any output.

## Test plan
- SLL with `rs1`=32'h0000_0001, shamt=4, `resp_ready_i`=1 → `result_o`=32'h0000_0010. `resp_valid_o` rises exactly 5 cycles after acceptance and stays high 1 cycle.
- SRA with `rs1`=32'h8000_0000, shamt=31 → 32'hFFFF_FFFF after 32 cycles. SRL with the same inputs → 32'h0000_0001.
- ROR with `rs1`=32'h0000_0001, shamt=1 → 32'h8000_0000. Any op with shamt=0 and `rs1`=32'hDEAD_BEEF → 32'hDEAD_BEEF in cycle c+1.
- Backpressure: `resp_ready_i`=0 for 10 cycles after `resp_valid_o` rises. `resp_valid_o`/`result_o` stay constant and `req_ready_o`=0 throughout. Assert ready → IDLE next cycle with `req_ready_o`=1.
- Reset mid-SHIFT: SLL with shamt=20, assert `rst_i` for 1 cycle after 5 shift cycles. Next cycle: `busy_o`=0, `resp_valid_o`=0, `result_o`=0, and no response ever appears for that request.
- Random regression: 1000 requests with random `op_i`/`rs1`/`shamt` and random `resp_ready_i` backpressure. Each result is compared against the `<<`, `>>`, `>>>` and rotate model, with every latency equal to shamt+1.
